// File: rtl/reg_writeback_pkg.sv
// Shared register-file types and defaults used by the writeback slice.
package reg_writeback_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_WIDTH-1:0]  word_t;

  // Register 0 reads as zero and is never written or tracked.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one pending-write bit per register, set on issue and
// cleared when the write reaches the register-file port.
module reg_scoreboard
  import reg_writeback_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_ready,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  input  logic [ADDR_W-1:0]   rs1_addr,
  input  logic [ADDR_W-1:0]   rs2_addr,
  output logic                rs1_pending,
  output logic                rs2_pending,
  output logic [NUM_REGS-1:0] busy
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic set_en;

  // A second writer to a busy register is held off (WAW); r0 never stalls.
  assign issue_ready = (issue_rd == ZERO_ADDR) || !busy[issue_rd];
  assign set_en      = issue_valid && issue_ready && (issue_rd != ZERO_ADDR);

  assign busy[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      logic busy_reg;

      // Per-register busy bit; a new issue takes priority over the retiring write.
      always_ff @(posedge clk) begin
        if (reset) begin
          busy_reg <= 1'b0;
        end else if (set_en && (issue_rd == ADDR_W'(gi))) begin
          busy_reg <= 1'b1;
        end else if (clr_en && (clr_addr == ADDR_W'(gi))) begin
          busy_reg <= 1'b0;
        end
      end

      assign busy[gi] = busy_reg;
    end
  endgenerate

  assign rs1_pending = busy[rs1_addr];
  assign rs2_pending = busy[rs2_addr];

endmodule

// File: rtl/reg_writeback.sv
// Writeback unit: arbitrates ALU and memory results onto the single
// registered register-file write port, with scoreboard and bypass.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]  alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [WIDTH-1:0]  rf_write_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              fwd1_valid,
  output logic              fwd2_valid,
  output logic [WIDTH-1:0]  fwd1_data,
  output logic [WIDTH-1:0]  fwd2_data,
  output logic              err_unexpected
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic                mem_xfer;
  logic                sel_valid;
  logic [ADDR_W-1:0]   sel_rd;
  logic [WIDTH-1:0]    sel_data;
  logic                sel_write;
  logic [NUM_REGS-1:0] busy;
  logic                rs1_pending;
  logic                rs2_pending;

  // ALU has strict priority; a stalled memory result stays on its inputs.
  assign mem_ready = !alu_valid;
  assign mem_xfer  = mem_valid && mem_ready;
  assign sel_valid = alu_valid || mem_xfer;
  assign sel_rd    = alu_valid ? alu_rd   : mem_rd;
  assign sel_data  = alu_valid ? alu_data : mem_data;
  assign sel_write = sel_valid && (sel_rd != ZERO_ADDR);

  // Single write register feeding the register-file port; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_en   <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      rf_write_en <= sel_write;
      if (sel_write) begin
        rf_write_addr <= sel_rd;
        rf_write_data <= sel_data;
      end
    end
  end

  // Sticky flag for a result targeting a register nobody issued to.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_unexpected <= 1'b0;
    end else if (sel_write && !busy[sel_rd]) begin
      err_unexpected <= 1'b1;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_en      (rf_write_en),
    .clr_addr    (rf_write_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .busy        (busy)
  );

  // Bypass the value sitting on the write port; the register file lags by one cycle.
  assign fwd1_valid = rf_write_en && (rf_write_addr == rs1_addr) && (rs1_addr != ZERO_ADDR);
  assign fwd2_valid = rf_write_en && (rf_write_addr == rs2_addr) && (rs2_addr != ZERO_ADDR);
  assign fwd1_data  = rf_write_data;
  assign fwd2_data  = rf_write_data;

  // A forwarded source is usable even though its busy bit clears only at cycle end.
  assign rs1_busy = rs1_pending && !fwd1_valid;
  assign rs2_busy = rs2_pending && !fwd2_valid;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed plus randomized bench for reg_writeback against a cycle-level
// reference model of the scoreboard, write port and error flag.
`timescale 1ns/1ps
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic        err_unexpected;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_err;
  bit          m_mem_stall;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_ready    (issue_ready),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .rf_write_en    (rf_write_en),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .fwd1_valid     (fwd1_valid),
    .fwd2_valid     (fwd2_valid),
    .fwd1_data      (fwd1_data),
    .fwd2_data      (fwd2_data),
    .err_unexpected (err_unexpected)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    mem_valid   = 1'b0;
  endtask

  // Check all outputs against the model, then advance one clock and update the model.
  task automatic tick();
    logic f1, f2, have;
    logic [4:0]  rd;
    logic [31:0] d;
    bit nb [32];
    #1;
    f1 = m_we && (m_wa == rs1_addr) && (rs1_addr != 0);
    f2 = m_we && (m_wa == rs2_addr) && (rs2_addr != 0);
    chk("mem_ready", 32'(mem_ready), 32'(!alu_valid));
    chk("issue_ready", 32'(issue_ready), 32'((issue_rd == 0) || !m_busy[issue_rd]));
    chk("rf_write_en", 32'(rf_write_en), 32'(m_we));
    chk("rf_write_addr", 32'(rf_write_addr), 32'(m_wa));
    chk("rf_write_data", rf_write_data, m_wd);
    chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
    chk("fwd1_valid", 32'(fwd1_valid), 32'(f1));
    chk("fwd2_valid", 32'(fwd2_valid), 32'(f2));
    chk("fwd1_data", fwd1_data, m_wd);
    chk("fwd2_data", fwd2_data, m_wd);
    chk("rs1_busy", 32'(rs1_busy), 32'(m_busy[rs1_addr] && !f1));
    chk("rs2_busy", 32'(rs2_busy), 32'(m_busy[rs2_addr] && !f2));
    @(posedge clk);
    m_mem_stall = mem_valid && alu_valid;
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0;
    end else begin
      // ALU wins; otherwise a waiting memory result goes.
      have = alu_valid || mem_valid;
      rd   = alu_valid ? alu_rd : mem_rd;
      d    = alu_valid ? alu_data : mem_data;
      nb   = m_busy;
      if (m_we) nb[m_wa] = 1'b0;
      if (issue_valid && issue_rd != 0 && !m_busy[issue_rd]) nb[issue_rd] = 1'b1;
      if (have && rd != 0) begin
        if (!m_busy[rd]) m_err = 1'b1;
        m_we = 1'b1; m_wa = rd; m_wd = d;
      end else begin
        m_we = 1'b0;
      end
      m_busy = nb;
    end
    @(negedge clk);
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_err = 1'b0; m_mem_stall = 1'b0;
    reset = 1'b1;
    idle();
    issue_rd = '0; alu_rd = '0; alu_data = '0; mem_rd = '0; mem_data = '0;
    rs1_addr = '0; rs2_addr = '0;
    @(negedge clk);
    tick();
    #1;
    chk("reset_we", 32'(rf_write_en), 32'd0);
    chk("reset_addr", 32'(rf_write_addr), 32'd0);
    chk("reset_data", rf_write_data, 32'd0);
    chk("reset_err", 32'(err_unexpected), 32'd0);
    tick();
    reset = 1'b0;

    // ALU path
    issue_valid = 1'b1; issue_rd = 5; tick();
    idle(); alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF; tick();
    idle(); rs1_addr = 5; #1;
    chk("alu_we", 32'(rf_write_en), 32'd1);
    chk("alu_addr", 32'(rf_write_addr), 32'd5);
    chk("alu_data", rf_write_data, 32'hDEADBEEF);
    tick();
    #1;
    chk("alu_busy_cleared", 32'(rs1_busy), 32'd0);
    chk("alu_no_err", 32'(err_unexpected), 32'd0);
    tick();

    // ALU / memory collision
    issue_valid = 1'b1; issue_rd = 3; tick();
    issue_rd = 4; tick();
    idle();
    alu_valid = 1'b1; alu_rd = 3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 4; mem_data = 32'h22; #1;
    chk("coll_mem_ready0", 32'(mem_ready), 32'd0);
    tick();
    alu_valid = 1'b0; #1;
    chk("coll_mem_ready1", 32'(mem_ready), 32'd1);
    chk("coll_w3_addr", 32'(rf_write_addr), 32'd3);
    chk("coll_w3_data", rf_write_data, 32'h11);
    tick();
    mem_valid = 1'b0; #1;
    chk("coll_w4_we", 32'(rf_write_en), 32'd1);
    chk("coll_w4_addr", 32'(rf_write_addr), 32'd4);
    chk("coll_w4_data", rf_write_data, 32'h22);
    tick();

    // Forwarding
    issue_valid = 1'b1; issue_rd = 7; tick();
    idle(); alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h1234; tick();
    idle(); rs1_addr = 7; rs2_addr = 0; #1;
    chk("fwd1_valid_hit", 32'(fwd1_valid), 32'd1);
    chk("fwd1_data_hit", fwd1_data, 32'h1234);
    chk("fwd_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("fwd2_valid_r0", 32'(fwd2_valid), 32'd0);
    tick();

    // WAW stall: busy clears only at the end of the write cycle
    issue_valid = 1'b1; issue_rd = 9; tick();
    #1; chk("waw_stall_a", 32'(issue_ready), 32'd0); tick();
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'hAA; #1;
    chk("waw_stall_b", 32'(issue_ready), 32'd0); tick();
    alu_valid = 1'b0; #1;
    chk("waw_write_addr", 32'(rf_write_addr), 32'd9);
    chk("waw_stall_c", 32'(issue_ready), 32'd0); tick();
    #1; chk("waw_ready", 32'(issue_ready), 32'd1); tick();
    idle(); rs1_addr = 9; #1;
    chk("waw_rebusy", 32'(rs1_busy), 32'd1); tick();
    alu_valid = 1'b1; alu_rd = 9; alu_data = 32'hBB; tick();
    idle(); tick();

    // Zero register
    issue_valid = 1'b1; issue_rd = 0; #1;
    chk("r0_issue_ready", 32'(issue_ready), 32'd1); tick();
    idle(); alu_valid = 1'b1; alu_rd = 0; alu_data = 32'hFFFFFFFF; tick();
    idle(); #1;
    chk("r0_no_write", 32'(rf_write_en), 32'd0);
    chk("r0_no_err", 32'(err_unexpected), 32'd0);
    tick();

    // Unexpected result; issue in the write cycle shows set beating clear
    alu_valid = 1'b1; alu_rd = 12; alu_data = 32'h5A5A; tick();
    idle(); issue_valid = 1'b1; issue_rd = 12; rs1_addr = 12; #1;
    chk("unexp_we", 32'(rf_write_en), 32'd1);
    chk("unexp_addr", 32'(rf_write_addr), 32'd12);
    chk("unexp_err", 32'(err_unexpected), 32'd1);
    chk("setwins_ready", 32'(issue_ready), 32'd1);
    tick();
    idle(); #1;
    chk("setwins_busy", 32'(rs1_busy), 32'd1);
    chk("unexp_sticky", 32'(err_unexpected), 32'd1);
    tick();

    // Reset the cycle after a memory result is accepted
    issue_valid = 1'b1; issue_rd = 20; tick();
    idle(); mem_valid = 1'b1; mem_rd = 20; mem_data = 32'h77; tick();
    idle(); reset = 1'b1; #1;
    chk("rst_inflight_addr", 32'(rf_write_addr), 32'd20);
    tick();
    reset = 1'b0; #1;
    chk("rst_we", 32'(rf_write_en), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); #1;
      chk("rst_busy_clear", 32'(rs1_busy), 32'd0);
      tick();
    end

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      reset       = ($urandom_range(63) == 0);
      alu_valid   = ($urandom_range(2) == 0);
      alu_rd      = 5'($urandom_range(7));
      alu_data    = $urandom();
      if (!m_mem_stall) begin
        mem_valid = ($urandom_range(1) == 0);
        mem_rd    = 5'($urandom_range(7));
        mem_data  = $urandom();
      end
      issue_valid = ($urandom_range(1) == 0);
      issue_rd    = 5'($urandom_range(7));
      rs1_addr    = 5'($urandom_range(7));
      rs2_addr    = 5'($urandom_range(7));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
